lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_LONG, default 2000, clock cycles busy after clear/home.
REQ-002 SHALL have parameter BUSY_SHORT, default 50, clock cycles busy after any other accepted transaction.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports lcd_rs, lcd_rw, lcd_en  input  1 each  HD44780 bus controls from the LCD driver.
REQ-006 SHALL have port lcd_data_in  input  8  bus data from the driver.
REQ-007 SHALL have port lcd_data_out  output  8  read-back data.
REQ-008 SHALL have port lcd_data_oe  output  1  high while a read drives lcd_data_out.
REQ-009 SHALL have port rd_addr  input  5  character-buffer index (0-15 line 1, 16-31 line 2).
REQ-010 SHALL have port rd_char  output  8  buffer contents at rd_addr.
REQ-011 SHALL have port cmd_valid  output  1  one-cycle pulse per accepted instruction (RS=0, RW=0).
REQ-012 SHALL have port cmd_code  output  8  last accepted instruction byte.
REQ-013 SHALL have port busy  output  1  emulated busy flag.
REQ-014 SHALL have port cursor  output  5  current address counter as buffer index.
REQ-015 SHALL have port overrun  output  1  sticky; set when a write arrives while busy.

Function
REQ-016 SHALL synchronise lcd_en/rs/rw/data_in through two flops; a transaction SHALL be captured on the synchronised lcd_en falling edge.
REQ-017 SHALL map DDRAM address A to index {A[6], A[3:0]}.
REQ-018 Instruction 0x01 (clear) SHALL enter state CLEAR, write 0x20 to all 32 entries one per cycle (32 cycles), then set AC=0, increment mode, BUSY.
REQ-019 Instruction 0x02/0x03 (home) SHALL set AC=0 and enter BUSY for BUSY_LONG.
REQ-020 Instructions 0x04-0x07 SHALL store I/D (bit 1); 0x08-0x0F SHALL store display-on (bit 2); 0x20-0x3F SHALL be accepted with no effect.
REQ-021 Instructions 0x10-0x1F with bit 3=0 SHALL move AC by +1 (bit 2=1) or -1; display shift (bit 3=1) SHALL be ignored.
REQ-022 Instructions 0x40-0x7F SHALL select CGRAM mode; subsequent data writes SHALL be discarded until a 0x80-0xFF instruction.
REQ-023 Instruction 0x80|A SHALL set AC per REQ-017 and leave CGRAM mode.
REQ-024 Data write (RS=1, RW=0) SHALL store lcd_data_in at AC, then step AC per I/D.
REQ-025 AC SHALL wrap modulo 32: 15+1->16, 31+1->0, 0-1->31, 16-1->15.
REQ-026 Status read (RS=0, RW=1) SHALL drive {busy, 2'b00, AC} while synchronised lcd_en and lcd_rw are high; data read (RS=1) SHALL drive buffer[AC] and step AC on the falling edge.
REQ-027 lcd_data_oe SHALL be low whenever lcd_rw or synchronised lcd_en is low.
REQ-028 States SHALL be IDLE, CLEAR, BUSY; BUSY->IDLE when the busy counter reaches 0; busy SHALL be high in CLEAR and BUSY.
REQ-029 A write captured while busy SHALL be dropped and set overrun; reads SHALL be served in any state.
REQ-030 rd_char SHALL be registered, one-cycle latency; same-cycle buffer write and rd_addr match SHALL return the old value.

Reset
REQ-031 On reset low: state IDLE, AC=0, I/D=increment, display off, CGRAM mode off, all 32 entries 0x20, cmd_code=0x00, cmd_valid=0, busy=0, overrun=0, lcd_data_oe=0, lcd_data_out=0x00, rd_char=0x20.
REQ-032 Reset during CLEAR or BUSY SHALL abort immediately to reset values; buffer fill SHALL complete within 32 cycles of reset release, with busy high throughout.

Configuration
REQ-033 With LCD_RESPONDER_BUSY_EN defined, busy timing per REQ-018/019/028/029; without it, BUSY state SHALL be omitted, busy SHALL be high only during CLEAR, overrun SHALL be tied 0.

Structure
REQ-034 Package lcd_pkg SHALL hold instruction opcode constants, state enum, line base addresses 0x00/0x40 and buffer depth 32.
REQ-035 Sub-module lcd_sync SHALL implement the two-flop synchroniser and falling-edge detect.

Verification
REQ-036 Reset release -> busy high 32 cycles, then rd_char=0x20 for all rd_addr.
REQ-037 Write 0x80, then data 'H','I' -> buffer[0]=0x48, buffer[1]=0x49, cursor=2.
REQ-038 Write 0xCF, data 'A', 'B' -> buffer[31]=0x41, buffer[0]=0x42, cursor=1.
REQ-039 Write 0x01, data write 3 cycles later -> data dropped, overrun=1, status read shows bit7=1 (BUSY_EN build).
REQ-040 Write 0x06, 0x85, status read -> lcd_data_out=0x05 when idle, lcd_data_oe high only during lcd_en high.
REQ-041 Assert reset mid-CLEAR -> all outputs at reset values next cycle, no partial state retained.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder: opcodes, FSM states,
// buffer geometry and DDRAM-address helpers.
package lcd_pkg;

  localparam int BUF_DEPTH = 32;
  localparam int IDX_W     = 5;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Instruction groups are identified by their highest set bit
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] ac;
    logic             id;
    logic             disp_on;
    logic             cgram;
  } ctl_t;

  function automatic logic [IDX_W-1:0] ddram_to_idx(input logic [6:0] addr);
    return {(addr & LINE2_BASE) != 7'h00, addr[3:0]};
  endfunction

  function automatic logic [IDX_W-1:0] step_ac(input logic [IDX_W-1:0] ac, input logic inc);
    return inc ? ac + IDX_W'(1) : ac - IDX_W'(1);
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchroniser for the LCD bus controls and data, with a falling-edge
// strobe on the synchronised enable.
module lcd_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       en_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] data_o,
  output logic       fall_o
);

  logic [10:0] s1_q;
  logic [10:0] s2_q;
  logic        en_prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      en_prev_q <= 1'b0;
    end else begin
      s1_q      <= {en_i, rs_i, rw_i, data_i};
      s2_q      <= s1_q;
      en_prev_q <= s2_q[10];
    end
  end

  assign {en_o, rs_o, rw_o, data_o} = s2_q;
  assign fall_o = en_prev_q & ~s2_q[10];

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD emulator: captures bus transactions, keeps a 2x16 character buffer.
// Define LCD_RESPONDER_BUSY_EN for timed busy/overrun emulation; otherwise busy only covers clear.
//
// state | meaning
// IDLE  | accepting writes
// CLEAR | filling the buffer with spaces, one entry per cycle
// BUSY  | emulated execution time after a write (LCD_RESPONDER_BUSY_EN only)
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_LONG  = 2000,
  parameter int BUSY_SHORT = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lcd_rs,
  input  logic             lcd_rw,
  input  logic             lcd_en,
  input  logic [7:0]       lcd_data_in,
  output logic [7:0]       lcd_data_out,
  output logic             lcd_data_oe,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_char,
  output logic             cmd_valid,
  output logic [7:0]       cmd_code,
  output logic             busy,
  output logic [IDX_W-1:0] cursor,
  output logic             overrun
);

  logic       en_s, rs_s, rw_s, fall_s;
  logic [7:0] data_s;

  lcd_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .en_i   (lcd_en),
    .rs_i   (lcd_rs),
    .rw_i   (lcd_rw),
    .data_i (lcd_data_in),
    .en_o   (en_s),
    .rs_o   (rs_s),
    .rw_o   (rw_s),
    .data_o (data_s),
    .fall_o (fall_s)
  );

  state_e           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             init_q, init_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic [7:0]       buf_q [BUF_DEPTH];
  logic [7:0]       rd_char_q;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic             wr_req, rd_req;

`ifdef LCD_RESPONDER_BUSY_EN
  localparam int CNT_W = $clog2((BUSY_LONG > BUSY_SHORT ? BUSY_LONG : BUSY_SHORT) + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
`endif

  assign wr_req = fall_s & ~rw_s;
  assign rd_req = fall_s &  rw_s;

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    clr_idx_d   = clr_idx_q;
    init_d      = init_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    wr_en       = 1'b0;
    wr_idx      = ctl_q.ac;
    wr_data     = data_s;
`ifdef LCD_RESPONDER_BUSY_EN
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
`endif

    // Reads are served in every state
    if (rd_req && rs_s) ctl_d.ac = step_ac(ctl_q.ac, ctl_q.id);

    unique case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (wr_req) begin
`ifdef LCD_RESPONDER_BUSY_EN
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(BUSY_SHORT - 1);
`endif
          if (rs_s) begin
            if (!ctl_q.cgram) begin
              wr_en    = 1'b1;
              ctl_d.ac = step_ac(ctl_q.ac, ctl_q.id);
            end
          end else begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = data_s;
            if (data_s == OP_CLEAR) begin
              state_d   = ST_CLEAR;
              clr_idx_d = '0;
            end else if ((data_s & ~8'h01) == OP_HOME) begin
              ctl_d.ac = ddram_to_idx(LINE1_BASE);
`ifdef LCD_RESPONDER_BUSY_EN
              cnt_d    = CNT_W'(BUSY_LONG - 1);
`endif
            end else if (data_s >= OP_DDRAM) begin
              ctl_d.ac    = ddram_to_idx(data_s[6:0]);
              ctl_d.cgram = 1'b0;
            end else if (data_s >= OP_CGRAM) begin
              ctl_d.cgram = 1'b1;
            end else if (data_s >= OP_SHIFT && data_s < OP_FUNC) begin
              // Display shift (bit 3) has no visible effect on the buffer
              if (!data_s[3]) ctl_d.ac = step_ac(ctl_q.ac, data_s[2]);
            end else if (data_s >= OP_DISPLAY && data_s < OP_SHIFT) begin
              ctl_d.disp_on = data_s[2];
            end else if (data_s >= OP_ENTRY && data_s < OP_DISPLAY) begin
              ctl_d.id = data_s[1];
            end
          end
        end
      end

      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx_q;
        wr_data   = CHAR_SPACE;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(BUF_DEPTH - 1)) begin
          ctl_d.ac = ddram_to_idx(LINE1_BASE);
          ctl_d.id = 1'b1;
          init_d   = 1'b0;
          state_d  = ST_IDLE;
`ifdef LCD_RESPONDER_BUSY_EN
          // The power-on fill is not a host command, so it skips the execution delay
          if (!init_q) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(BUSY_LONG - 1);
          end
`endif
        end
`ifdef LCD_RESPONDER_BUSY_EN
        if (wr_req) ovr_d = 1'b1;
`endif
      end

`ifdef LCD_RESPONDER_BUSY_EN
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
        if (wr_req) ovr_d = 1'b1;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ctl_q.ac      <= ddram_to_idx(LINE1_BASE);
      ctl_q.id      <= 1'b1;
      ctl_q.disp_on <= 1'b0;
      ctl_q.cgram   <= 1'b0;
      clr_idx_q     <= '0;
      init_q        <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'h00;
      rd_char_q     <= CHAR_SPACE;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= CHAR_SPACE;
`ifdef LCD_RESPONDER_BUSY_EN
      cnt_q         <= '0;
      ovr_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      clr_idx_q   <= clr_idx_d;
      init_q      <= init_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      rd_char_q   <= buf_q[rd_addr];
      if (wr_en) buf_q[wr_idx] <= wr_data;
`ifdef LCD_RESPONDER_BUSY_EN
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign cursor       = ctl_q.ac;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign rd_char      = rd_char_q;
  assign lcd_data_oe  = en_s & rw_s & lcd_rw;
  assign lcd_data_out = !lcd_data_oe ? 8'h00 :
                        (rs_s ? buf_q[ctl_q.ac] : {busy, 2'b00, ctl_q.ac});

`ifdef LCD_RESPONDER_BUSY_EN
  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// Randomised bench for lcd_responder: a behavioural model predicts command codes and bus
// read data into queues; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_lcd_responder;

  localparam int BL = 40;
  localparam int BS = 6;
`ifdef LCD_RESPONDER_BUSY_EN
  localparam bit BUSY_BUILD = 1'b1;
`else
  localparam bit BUSY_BUILD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] lcd_data_out, rd_char, cmd_code;
  logic       lcd_data_oe, cmd_valid, busy, overrun;
  logic [4:0] cursor;

  int checks = 0;
  int failures = 0;

  byte unsigned m_buf [32];
  int           m_ac;
  bit           m_inc;
  bit           m_cgram;
  byte unsigned exp_cmd_q [$];
  byte unsigned exp_rd_q [$];
  byte unsigned mon_e;
  bit           mon_skip = 1'b0;
  logic         oe_prev = 1'b0;

  byte unsigned wrap_mode [4] = '{8'h06, 8'h06, 8'h04, 8'h04};
  byte unsigned wrap_addr [4] = '{8'h8F, 8'hCF, 8'h80, 8'hC0};
  int           wrap_exp  [4] = '{16, 0, 31, 15};

  lcd_responder #(.BUSY_LONG(BL), .BUSY_SHORT(BS)) dut (
    .clock        (clock),
    .reset        (reset),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .busy         (busy),
    .cursor       (cursor),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmd_valid === 1'b1) begin
      if (exp_cmd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_valid: unexpected pulse with code 0x%0h", cmd_code);
      end else begin
        mon_e = exp_cmd_q.pop_front();
        check("cmd_code", cmd_code, mon_e);
      end
    end
    if (lcd_data_oe === 1'b1 && oe_prev !== 1'b1 && !mon_skip) begin
      if (exp_rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_data: unexpected drive 0x%0h", lcd_data_out);
      end else begin
        mon_e = exp_rd_q.pop_front();
        check("read_data", lcd_data_out, mon_e);
      end
    end
    if (lcd_data_oe === 1'b1 && lcd_rw !== 1'b1) begin
      checks++; failures++;
      $display("FAIL oe_without_rw: oe=%b rw=%b", lcd_data_oe, lcd_rw);
    end
    oe_prev = lcd_data_oe;
  end

  function automatic int step(input int ac, input bit inc);
    return inc ? (ac + 1) % 32 : (ac + 31) % 32;
  endfunction

  task automatic model_reset();
    foreach (m_buf[i]) m_buf[i] = 8'h20;
    m_ac = 0; m_inc = 1'b1; m_cgram = 1'b0;
  endtask

  task automatic model_cmd(input byte unsigned c);
    if (c == 1) begin
      foreach (m_buf[i]) m_buf[i] = 8'h20;
      m_ac = 0; m_inc = 1'b1;
    end else if (c == 2 || c == 3) m_ac = 0;
    else if (c >= 4 && c <= 7) m_inc = ((c / 2) % 2) != 0;
    else if (c >= 16 && c <= 31) begin
      if ((c / 8) % 2 == 0) m_ac = step(m_ac, ((c / 4) % 2) != 0);
    end else if (c >= 64 && c <= 127) m_cgram = 1'b1;
    else if (c >= 128) begin
      m_ac = (((c / 64) % 2) != 0 ? 16 : 0) + (c % 16);
      m_cgram = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic bus_cycle(input bit rs, input bit rw, input byte unsigned d);
    @(negedge clock);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
    @(negedge clock);
    lcd_en = 1'b1;
    repeat (4) @(negedge clock);
    lcd_en = 1'b0;
    repeat (6) @(negedge clock);
    lcd_rw = 1'b0;
  endtask

  task automatic do_cmd(input byte unsigned c);
    wait_idle();
    exp_cmd_q.push_back(c);
    model_cmd(c);
    bus_cycle(1'b0, 1'b0, c);
    wait_idle();
  endtask

  task automatic do_data(input byte unsigned d);
    wait_idle();
    if (!m_cgram) begin
      m_buf[m_ac] = d;
      m_ac = step(m_ac, m_inc);
    end
    bus_cycle(1'b1, 1'b0, d);
    wait_idle();
  endtask

  task automatic do_read(input bit rs);
    wait_idle();
    if (rs) begin
      exp_rd_q.push_back(m_buf[m_ac]);
      m_ac = step(m_ac, m_inc);
    end else begin
      exp_rd_q.push_back(8'(m_ac));
    end
    bus_cycle(rs, 1'b1, 8'h00);
    check("oe_after_read", lcd_data_oe, 0);
  endtask

  task automatic check_char(input int a);
    @(negedge clock);
    rd_addr = 5'(a);
    @(negedge clock);
    check("rd_char", rd_char, m_buf[a]);
  endtask

  task automatic sweep();
    for (int a = 0; a < 32; a++) check_char(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cursor"}, cursor, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_code"}, cmd_code, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_oe"}, lcd_data_oe, 0);
    check({tag, "_data_out"}, lcd_data_out, 0);
    check({tag, "_rd_char"}, rd_char, 8'h20);
  endtask

  task automatic check_init_busy();
    int n = 0;
    int w = 0;
    while (busy !== 1'b1 && w < 5) begin
      @(negedge clock);
      w++;
    end
    while (busy === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("init_busy_cycles", n, 32);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    check_init_busy();
    sweep();

    do_cmd(8'h80); do_data(8'h48); do_data(8'h49);
    check_char(0); check_char(1);
    check("cursor_hi", cursor, 2);

    do_cmd(8'hCF); do_data(8'h41); do_data(8'h42);
    check_char(31); check_char(0);
    check("cursor_wrap_ab", cursor, 1);

    for (int i = 0; i < 4; i++) begin
      do_cmd(wrap_mode[i]);
      do_cmd(wrap_addr[i]);
      do_data(8'(8'h30 + i));
      check("cursor_wrap", cursor, wrap_exp[i]);
    end

    do_cmd(8'h06); do_cmd(8'h85); do_read(1'b0);
    check("cursor_status", cursor, 5);

    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3)      do_cmd(8'($urandom_range(0, 255)));
      else if (r <= 6) do_data(8'($urandom_range(0, 255)));
      else if (r == 7) do_read(1'b1);
      else if (r == 8) do_read(1'b0);
      else             check_char($urandom_range(0, 31));
      if (r <= 8) check("cursor", cursor, m_ac);
    end
    sweep();

    // Write arriving during clear is dropped; status read while clearing reports busy
    wait_idle();
    exp_cmd_q.push_back(8'h01);
    model_cmd(8'h01);
    bus_cycle(1'b0, 1'b0, 8'h01);
    bus_cycle(1'b1, 1'b0, 8'h5A);
    mon_skip = 1'b1;
    @(negedge clock);
    lcd_rs = 1'b0; lcd_rw = 1'b1;
    @(negedge clock);
    lcd_en = 1'b1;
    repeat (3) @(negedge clock);
    check("busy_status_oe", lcd_data_oe, 1);
    check("busy_status_bit7", lcd_data_out[7], 1);
    lcd_en = 1'b0;
    repeat (6) @(negedge clock);
    lcd_rw = 1'b0;
    mon_skip = 1'b0;
    wait_idle();
    check("overrun", overrun, BUSY_BUILD);
    check("cursor_after_clear", cursor, 0);
    sweep();

    // Reset in the middle of a clear
    do_cmd(8'h84); do_data(8'h77); do_data(8'h78);
    exp_cmd_q.push_back(8'h01);
    model_cmd(8'h01);
    bus_cycle(1'b0, 1'b0, 8'h01);
    repeat (4) @(negedge clock);
    check("busy_mid_clear", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midclear");
    reset = 1'b1;
    model_reset();
    check_init_busy();
    sweep();
    check("cursor_after_reset", cursor, 0);

    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
